// File: rtl/vga_pkg.sv
//==============================================================================
// Module      : vga_pkg
// Description : Shared constants and FSM state type for the glyph plotter.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package vga_pkg;
    localparam int GLYPH_DIM  = 16;
    localparam int GLYPH_BITS = 256;
    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int COLOUR_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } plot_state_t;
endpackage

`default_nettype wire

// File: rtl/glyph_plotter_if.sv
//==============================================================================
// Module      : glyph_plotter_if
// Description : Start handshake, glyph request and pixel-write bus.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface glyph_plotter_if #(
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                ready;
    logic [255:0]        glyph;
    logic [8:0]          x0;
    logic [7:0]          y0;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;
    logic                transparent;
    logic [8:0]          out_x;
    logic [7:0]          out_y;
    logic [COLOUR_W-1:0] out_colour;
    logic                plot;
    logic                done;

    modport master (
        output start, glyph, x0, y0, fg_colour, bg_colour, transparent,
        input  ready, out_x, out_y, out_colour, plot, done
    );

    modport slave (
        input  start, glyph, x0, y0, fg_colour, bg_colour, transparent,
        output ready, out_x, out_y, out_colour, plot, done
    );
endinterface

`default_nettype wire

// File: rtl/glyph_pixel_counter.sv
//==============================================================================
// Module      : glyph_pixel_counter
// Description : Raster col/row counter over the glyph cell, flags the last pixel.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module glyph_pixel_counter
    import vga_pkg::*;
#(
    parameter int CNT_W = $clog2(GLYPH_DIM)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_enable,
    output logic      [CNT_W-1:0] o_col,
    output logic      [CNT_W-1:0] o_row,
    output logic                  o_last
);
    localparam logic [CNT_W-1:0] c_max = CNT_W'(GLYPH_DIM - 1);

    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_enable) begin
            r_col <= r_col + 1'b1;
            if (r_col == c_max) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (r_col == c_max) && (r_row == c_max);
endmodule

`default_nettype wire

// File: rtl/glyph_plotter.sv
//==============================================================================
// Module      : glyph_plotter
// Description : Rasterises a latched 16x16 glyph into clipped pixel writes.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module glyph_plotter #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int COLOUR_W = vga_pkg::COLOUR_W
) (
    input  wire logic      clk,
    input  wire logic      reset,
    glyph_plotter_if.slave bus
);
    import vga_pkg::*;

    plot_state_t           r_state;
    plot_state_t           w_next;
    logic                  w_accept;
    logic                  w_ready;

    logic [GLYPH_BITS-1:0] r_glyph;
    logic [8:0]            r_x0;
    logic [7:0]            r_y0;
    logic [COLOUR_W-1:0]   r_fg;
    logic [COLOUR_W-1:0]   r_bg;
    logic                  r_transparent;

    logic [8:0]            r_out_x;
    logic [7:0]            r_out_y;
    logic [COLOUR_W-1:0]   r_out_colour;
    logic                  r_plot;
    logic                  r_done;

    logic [3:0]            w_col;
    logic [3:0]            w_row;
    logic                  w_last;
    logic                  w_bit;
    logic [9:0]            w_sum_x;
    logic [8:0]            w_sum_y;
    logic                  w_write;

    glyph_pixel_counter #(
        .CNT_W (4)
    ) u_counter (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_accept),
        .i_enable (r_state == DRAW),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_last   (w_last)
    );

    // The done cycle is spent in IDLE with r_done high, so ready stays low
    // until the cycle after the done pulse.
    assign w_ready = (r_state == IDLE) && !r_done;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && w_ready) begin
                    w_accept = 1'b1;
                    w_next   = DRAW;
                end
            end
            DRAW: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Widened sums so an origin near the top of the 9/8-bit range cannot
    // wrap back onto the screen.
    assign w_bit   = r_glyph[{w_row, w_col}];
    assign w_sum_x = {1'b0, r_x0} + {6'd0, w_col};
    assign w_sum_y = {1'b0, r_y0} + {5'd0, w_row};
    assign w_write = (w_bit || !r_transparent)
                     && (w_sum_x < 10'(SCREEN_W))
                     && (w_sum_y < 9'(SCREEN_H));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_glyph       <= '0;
            r_x0          <= '0;
            r_y0          <= '0;
            r_fg          <= '0;
            r_bg          <= '0;
            r_transparent <= 1'b0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_out_colour  <= '0;
            r_plot        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_glyph       <= bus.glyph;
                r_x0          <= bus.x0;
                r_y0          <= bus.y0;
                r_fg          <= bus.fg_colour;
                r_bg          <= bus.bg_colour;
                r_transparent <= bus.transparent;
            end
            if (r_state == DRAW) begin
                r_out_x      <= w_sum_x[8:0];
                r_out_y      <= w_sum_y[7:0];
                r_out_colour <= w_bit ? r_fg : r_bg;
                r_plot       <= w_write;
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.out_x      = r_out_x;
    assign bus.out_y      = r_out_y;
    assign bus.out_colour = r_out_colour;
    assign bus.plot       = r_plot;
    assign bus.done       = r_done;
endmodule

`default_nettype wire

// File: tb/tb_glyph_plotter.sv
//==============================================================================
// Module      : tb_glyph_plotter
// Description : Scoreboard bench for glyph_plotter draw, clip, handshake, reset.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_glyph_plotter;
    logic clk;
    logic reset;

    glyph_plotter_if #(.COLOUR_W(3)) bus ();

    glyph_plotter #(
        .SCREEN_W (320),
        .SCREEN_H (240),
        .COLOUR_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one glyph and follow it through 260 cycles, scoring every write.
    task automatic run_glyph(input logic [255:0] g, input int x0, input int y0,
                             input int fg, input int bg, input logic tr,
                             input bit spurious, input string tag);
        int   n_exp;
        int   n_plot;
        int   n_done;
        int   done_at;
        exp_t e;
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int  px;
                int  py;
                logic b;
                px = x0 + c;
                py = y0 + r;
                b  = g[16*r + c];
                if (!(tr && !b) && px < 320 && py < 240) begin
                    e.x = px; e.y = py; e.c = b ? fg : bg; e.t = 16*r + c + 1;
                    exp_q.push_back(e);
                end
            end
        end
        n_exp   = exp_q.size();
        n_plot  = 0;
        n_done  = 0;
        done_at = -1;

        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_start: got %b, required 1", tag, bus.ready);
        end
        bus.glyph       = g;
        bus.x0          = 9'(x0);
        bus.y0          = 8'(y0);
        bus.fg_colour   = 3'(fg);
        bus.bg_colour   = 3'(bg);
        bus.transparent = tr;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.glyph       = ~g;
        bus.x0          = 9'($urandom);
        bus.y0          = 8'($urandom);
        bus.fg_colour   = ~bus.fg_colour;
        bus.bg_colour   = ~bus.bg_colour;
        bus.transparent = ~tr;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after_accept: got %b, required 0", tag, bus.ready);
        end

        for (int n = 1; n <= 260; n++) begin
            @(negedge clk);
            bus.start = spurious && (n == 4 || n == 99);
            if (bus.plot === 1'b1) begin
                n_plot++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_plot: got x=%0d y=%0d at cycle %0d, required no write",
                             tag, bus.out_x, bus.out_y, n);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.out_x) !== e.x || int'(bus.out_y) !== e.y ||
                        int'(bus.out_colour) !== e.c || n !== e.t) begin
                        errors++;
                        $display("FAIL %s pixel: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                                 tag, bus.out_x, bus.out_y, bus.out_colour, n, e.x, e.y, e.c, e.t);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                n_done++;
                done_at = n;
                checks++;
                if (bus.plot !== 1'b0) begin
                    errors++;
                    $display("FAIL %s plot_during_done: got %b, required 0", tag, bus.plot);
                end
            end
            if (n == 257) begin
                checks++;
                if (bus.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_in_done_cycle: got %b, required 0", tag, bus.ready);
                end
            end
            if (n == 258) begin
                checks++;
                if (bus.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready_return: got %b, required 1", tag, bus.ready);
                end
            end
        end
        bus.start = 1'b0;

        checks++;
        if (n_plot !== n_exp) begin
            errors++;
            $display("FAIL %s write_count: got %0d, required %0d", tag, n_plot, n_exp);
        end
        checks++;
        if (n_done !== 1 || done_at !== 257) begin
            errors++;
            $display("FAIL %s done: got %0d pulses last at cycle %0d, required 1 at cycle 257",
                     tag, n_done, done_at);
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.glyph       = '0;
        bus.x0          = '0;
        bus.y0          = '0;
        bus.fg_colour   = '0;
        bus.bg_colour   = '0;
        bus.transparent = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got plot=%b done=%b ready=%b, required 0 0 1",
                     bus.plot, bus.done, bus.ready);
        end
        checks++;
        if (bus.out_x !== 9'd0 || bus.out_y !== 8'd0 || bus.out_colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: got x=%0d y=%0d c=%0d, required 0 0 0",
                     bus.out_x, bus.out_y, bus.out_colour);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plain_draw();
        run_glyph('1, 100, 50, 7, 0, 1'b0, 1'b0, "plain");
    endtask

    task automatic test_bit_mapping();
        logic [255:0] g;
        g = '0;
        g[16*3 + 5] = 1'b1;
        run_glyph(g, 0, 0, 4, 1, 1'b1, 1'b0, "bitmap");
    endtask

    task automatic test_random_glyph();
        logic [255:0] g;
        for (int i = 0; i < 8; i++) g[32*i +: 32] = $urandom();
        run_glyph(g, 37, 200, 6, 3, 1'b0, 1'b0, "random_opaque");
        for (int i = 0; i < 8; i++) g[32*i +: 32] = $urandom();
        run_glyph(g, 305, 12, 5, 2, 1'b1, 1'b0, "random_transp");
    endtask

    task automatic test_clipping();
        run_glyph('1, 310, 232, 5, 0, 1'b0, 1'b0, "clip_corner");
        run_glyph('1, 505, 10, 5, 0, 1'b0, 1'b0, "clip_xwrap");
        run_glyph('1, 10, 250, 5, 0, 1'b0, 1'b0, "clip_ywrap");
    endtask

    task automatic test_handshake();
        logic [255:0] g;
        for (int i = 0; i < 8; i++) g[32*i +: 32] = $urandom();
        run_glyph(g, 20, 30, 3, 6, 1'b0, 1'b1, "handshake");
    endtask

    task automatic test_reset_mid_draw();
        int bad;
        @(negedge clk);
        bus.glyph       = '1;
        bus.x0          = 9'd40;
        bus.y0          = 8'd60;
        bus.fg_colour   = 3'd7;
        bus.bg_colour   = 3'd0;
        bus.transparent = 1'b0;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (121) @(negedge clk);
        checks++;
        if (bus.plot !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got plot=%b, required 1", bus.plot);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: got plot=%b done=%b ready=%b, required 0 0 1",
                     bus.plot, bus.done, bus.ready);
        end
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.plot !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.plot !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d active cycles, required 0", bad);
        end
        run_glyph('1, 200, 100, 1, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_background();
        run_glyph('0, 64, 64, 5, 2, 1'b0, 1'b0, "bg_opaque");
        run_glyph('0, 64, 64, 5, 2, 1'b1, 1'b0, "bg_transp");
    endtask

    task automatic test_back_to_back();
        run_glyph('1, 0, 0, 2, 0, 1'b0, 1'b0, "b2b_first");
        run_glyph('0, 304, 224, 0, 7, 1'b0, 1'b0, "b2b_second");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_plain_draw();
        test_bit_mapping();
        test_random_glyph();
        test_clipping();
        test_handshake();
        test_reset_mid_draw();
        test_background();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
